// File: rtl/serializer16_pkg.sv
// Shared definitions for the serializer16 bit-serial transmitter.
package serializer16_pkg;

  // Frame sequencing states; ST_PARITY is only reachable when the parity
  // trailer is compiled in.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  // Default datapath word width.
  localparam int unsigned SER_WIDTH_DEF = 16;

  // Parity polarity: 0 gives even parity (frame 1-count is even).
  localparam logic PARITY_ODD = 1'b0;

endpackage

// File: rtl/parity16.sv
// Combinational parity of the latched word for the serializer16 trailer beat.
module parity16
  import serializer16_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] word_i,
  output logic             parity_o
);

  // XOR-reduce the word and apply the package polarity.
  always_comb begin
    parity_o = (^word_i) ^ PARITY_ODD;
  end

endmodule

// File: rtl/serializer16.sv
// Parallel-to-serial transmitter: accepts one word over valid/ready and
// shifts it out one bit per accepted beat with first/last markers.
// Define SERIALIZER16_PARITY_EN to append an even-parity trailer beat.
module serializer16
  import serializer16_pkg::*;
#(
  parameter int unsigned WIDTH     = SER_WIDTH_DEF,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             data_bit;
  logic [WIDTH-1:0] shifted;

`ifdef SERIALIZER16_PARITY_EN
  // The shift register is consumed as the frame goes out, so the original
  // word is kept separately for the trailer.
  logic [WIDTH-1:0] word_q, word_d;
  logic             par_bit;

  parity16 #(.WIDTH(WIDTH)) u_parity (
    .word_i   (word_q),
    .parity_o (par_bit)
  );
`endif

  // Output end of the shift register and its one-step shifted image.
  always_comb begin
    data_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    shifted  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                         : {1'b0, shreg_q[WIDTH-1:1]};
  end

  // State, shift register and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef SERIALIZER16_PARITY_EN
      word_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef SERIALIZER16_PARITY_EN
      word_q  <= word_d;
`endif
    end
  end

  // Next-state and output decode from registered state only.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
`ifdef SERIALIZER16_PARITY_EN
    word_d     = word_q;
`endif
    in_ready   = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    sout_first = 1'b0;
    sout_last  = 1'b0;
    busy       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d = in;
          cnt_d   = '0;
`ifdef SERIALIZER16_PARITY_EN
          word_d  = in;
`endif
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        sout_valid = 1'b1;
        busy       = 1'b1;
        sout       = data_bit;
        sout_first = (cnt_q == '0);
`ifndef SERIALIZER16_PARITY_EN
        sout_last  = (cnt_q == LAST_CNT);
`endif
        if (sout_ready) begin
          shreg_d = shifted;
          // Counter stops at WIDTH-1 rather than wrapping; it is reloaded
          // on the next accept.
          if (cnt_q == LAST_CNT) begin
`ifdef SERIALIZER16_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

`ifdef SERIALIZER16_PARITY_EN
      ST_PARITY: begin
        sout_valid = 1'b1;
        busy       = 1'b1;
        sout       = par_bit;
        sout_last  = 1'b1;
        if (sout_ready) begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
